// File: rtl/add_operand_loader_pkg.sv
// Shared definitions for the element-wise add execution unit front end.
package add_operand_loader_pkg;

    // Lane count of the add unit and width of one activation-buffer beat.
    localparam int unsigned LANES  = 176;
    localparam int unsigned BEAT_W = 128;

    typedef logic        [15:0] scale_t;
    typedef logic signed [7:0]  zp_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StOut
    } loader_state_e;

endpackage

// File: rtl/add_operand_loader_vec_assembler.sv
// Builds one N-lane operand vector from W-bit beats: a beat counter selects which
// W-bit slice the accepted beat lands in; done pulses on the last beat's acceptance.
module vec_assembler
    import add_operand_loader_pkg::*;
#(
    parameter int unsigned N = LANES,
    parameter int unsigned W = BEAT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic [W-1:0]   data,
    output logic [N*8-1:0] vec,
    output logic           done
);

    localparam int unsigned BEATS = (N * 8) / W;
    localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

    logic [CntW-1:0]  cnt_q;
    logic [N*8-1:0]   vec_q;

    assign done = en && (cnt_q == LastCnt);
    assign vec  = vec_q;

    // Slice write plus counter; the counter wraps to 0 itself after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vec_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_q == CntW'(k)) begin
                    vec_q[k*W +: W] <= data;
                end
            end
            cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/add_operand_loader.sv
// Loads operands a then b from a narrow beat stream, latches the per-operation
// scaling, and hands everything to the add stage under valid/ready.
module add_operand_loader
    import add_operand_loader_pkg::*;
#(
    parameter int unsigned N = LANES,
    parameter int unsigned W = BEAT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           flush,
    input  scale_t         s_a_in,
    input  scale_t         s_b_in,
    input  zp_t            z_tot_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*8-1:0] a,
    output logic [N*8-1:0] b,
    output scale_t         s_a,
    output scale_t         s_b,
    output zp_t            z_tot,
    output logic           busy
);

    if ((N * 8) % W != 0) begin : g_bad_beat_width
        $error("add_operand_loader: N*8 must be a multiple of W");
    end

    loader_state_e state_q, state_d;
    scale_t        s_a_q, s_b_q;
    zp_t           z_tot_q;
    logic          latch_scale;
    logic          clr_cnt;
    logic          en_a, en_b;
    logic          done_a, done_b;

    // Flush blocks the beat in its own cycle so nothing is half-written.
    assign in_ready  = !flush && ((state_q == StLoadA) || (state_q == StLoadB));
    assign en_a      = in_valid && in_ready && (state_q == StLoadA);
    assign en_b      = in_valid && in_ready && (state_q == StLoadB);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        latch_scale = 1'b0;
        clr_cnt     = 1'b0;
        if (flush) begin
            state_d = StIdle;
            clr_cnt = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d     = StLoadA;
                        latch_scale = 1'b1;
                        clr_cnt     = 1'b1;
                    end
                end
                StLoadA: begin
                    if (done_a) state_d = StLoadB;
                end
                StLoadB: begin
                    if (done_b) state_d = StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        // Back-to-back start skips IDLE entirely.
                        if (start) begin
                            state_d     = StLoadA;
                            latch_scale = 1'b1;
                            clr_cnt     = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Scaling registers, captured only when an operation is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_a_q   <= '0;
            s_b_q   <= '0;
            z_tot_q <= '0;
        end else if (latch_scale) begin
            s_a_q   <= s_a_in;
            s_b_q   <= s_b_in;
            z_tot_q <= z_tot_in;
        end
    end

    assign s_a   = s_a_q;
    assign s_b   = s_b_q;
    assign z_tot = z_tot_q;

    vec_assembler #(
        .N (N),
        .W (W)
    ) u_asm_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .en    (en_a),
        .data  (in_data),
        .vec   (a),
        .done  (done_a)
    );

    vec_assembler #(
        .N (N),
        .W (W)
    ) u_asm_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .en    (en_b),
        .data  (in_data),
        .vec   (b),
        .done  (done_b)
    );

endmodule

// File: tb/tb_add_operand_loader.sv
// Self-checking bench for add_operand_loader: table-driven loads plus hand-written
// backpressure, back-to-back, flush and asynchronous-reset sequences.
module tb_add_operand_loader;

    localparam int N     = 176;
    localparam int W     = 128;
    localparam int BEATS = N * 8 / W;
    localparam int BPB   = W / 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, flush;
    logic [15:0]    s_a_in, s_b_in;
    logic [7:0]     z_tot_in;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N*8-1:0] a, b;
    logic [15:0]    s_a, s_b;
    logic [7:0]     z_tot;
    logic           busy;

    add_operand_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .s_a_in    (s_a_in),
        .s_b_in    (s_b_in),
        .z_tot_in  (z_tot_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .s_a       (s_a),
        .s_b       (s_b),
        .z_tot     (z_tot),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Beats of the current operation: 0..BEATS-1 form a, BEATS..2*BEATS-1 form b.
    logic [W-1:0] beats [2*BEATS];

    typedef struct {
        logic [15:0] sa;
        logic [15:0] sb;
        logic [7:0]  z;
        int          data_kind;  // 0: beat k is all bytes k, 1: random
        int          mode;       // 0: in_valid always, 1: toggling, 2: random
        int          exp_edges;  // start edge to out_valid, -1 when not fixed
    } vec_rec_t;

    vec_rec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [N*8-1:0] got,
                           input logic [N*8-1:0] exp);
        checks++;
        if (got !== exp) begin
            int lane = 0;
            failures++;
            for (int i = N - 1; i >= 0; i--) if (got[i*8 +: 8] !== exp[i*8 +: 8]) lane = i;
            $display("FAIL %s lane %0d got=%02h exp=%02h", name, lane,
                     got[lane*8 +: 8], exp[lane*8 +: 8]);
        end
    endtask

    // Operand as the add unit sees it: lane i is byte (i mod 16) of beat base + i/16.
    function automatic logic [N*8-1:0] model_vec(input int base);
        logic [N*8-1:0] v;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] bt;
            bt = beats[base + i / BPB];
            v[i*8 +: 8] = bt[(i % BPB)*8 +: 8];
        end
        return v;
    endfunction

    task automatic fill_beats(input int kind);
        for (int k = 0; k < 2*BEATS; k++) begin
            if (kind == 0) begin
                for (int j = 0; j < BPB; j++) beats[k][j*8 +: 8] = 8'(k);
            end else begin
                for (int w = 0; w < W/32; w++) beats[k][w*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] sa, input logic [15:0] sb, input logic [7:0] z);
        start    = 1'b1;
        s_a_in   = sa;
        s_b_in   = sb;
        z_tot_in = z;
        @(posedge clk); #1;
        start    = 1'b0;
        s_a_in   = $urandom;
        s_b_in   = $urandom;
        z_tot_in = $urandom;
    endtask

    // Streams nbeats beats; the loader must be ready in every cycle of the stream.
    task automatic stream(input int mode, input int nbeats, output int edges);
        int sent = 0;
        int cyc  = 0;
        logic ir_bad = 1'b0;
        while (sent < nbeats && cyc < 200) begin
            logic v;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? beats[sent] : {W/32{$urandom}};
            #1;
            if (in_ready !== 1'b1) ir_bad = 1'b1;
            if (v) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("in_ready_during_load", ir_bad, 1'b0);
        chk("beats_sent", sent, nbeats);
        edges = cyc;
    endtask

    task automatic verify_out(input logic [15:0] sa, input logic [15:0] sb, input logic [7:0] z);
        chk("out_valid_after_load", out_valid, 1'b1);
        chk("in_ready_in_out", in_ready, 1'b0);
        chk("busy_in_out", busy, 1'b1);
        chk_vec("vec_a", a, model_vec(0));
        chk_vec("vec_b", b, model_vec(BEATS));
        chk("s_a", s_a, sa);
        chk("s_b", s_b, sb);
        chk("z_tot", z_tot, z);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("busy_after_handshake", busy, 1'b0);
        chk("out_valid_after_handshake", out_valid, 1'b0);
        chk("in_ready_idle", in_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        logic [N*8-1:0] prev_a, prev_b, exp_a, new_a;
        logic [15:0] sa;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; s_a_in = '0; s_b_in = '0; z_tot_in = '0;

        tbl[0] = '{16'h4000, 16'h2000, 8'hFD, 0, 0, 2*BEATS + 1};
        tbl[1] = '{16'h4000, 16'h2000, 8'hFD, 0, 1, 4*BEATS};
        tbl[2] = '{16'($urandom), 16'($urandom), 8'($urandom), 1, 0, 2*BEATS + 1};
        tbl[3] = '{16'($urandom), 16'($urandom), 8'($urandom), 1, 2, -1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk_vec("reset_a", a, '0);
        chk_vec("reset_b", b, '0);
        chk("reset_s_a", s_a, 16'h0);
        chk("reset_z_tot", z_tot, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven loads.
        for (int i = 0; i < 4; i++) begin
            fill_beats(tbl[i].data_kind);
            do_start(tbl[i].sa, tbl[i].sb, tbl[i].z);
            stream(tbl[i].mode, 2*BEATS, edges);
            if (tbl[i].exp_edges >= 0) chk("start_to_out_valid", edges + 1, tbl[i].exp_edges);
            verify_out(tbl[i].sa, tbl[i].sb, tbl[i].z);
            if (tbl[i].data_kind == 0) begin
                chk("a_lane0", a[7:0], 8'h00);
                chk("a_lane175", a[175*8 +: 8], 8'h0A);
                chk("b_lane0", b[7:0], 8'h0B);
            end
            handshake();
        end

        // Output backpressure: operands must hold while in_valid carries junk.
        fill_beats(1);
        do_start(16'h0F0F, 16'h3333, 8'h7F);
        stream(2, 2*BEATS, edges);
        verify_out(16'h0F0F, 16'h3333, 8'h7F);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = {W/32{$urandom}};
            #1;
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1'b1);
            chk_vec("bp_a", a, model_vec(0));
            chk_vec("bp_b", b, model_vec(BEATS));
            chk("bp_s_b", s_b, 16'h3333);
        end
        in_valid = 1'b0;
        handshake();

        // Back-to-back: start in the handshake cycle goes straight to loading.
        fill_beats(1);
        do_start(16'hAAAA, 16'h5555, 8'h01);
        stream(0, 2*BEATS, edges);
        verify_out(16'hAAAA, 16'h5555, 8'h01);
        fill_beats(1);
        out_ready = 1'b1;
        start     = 1'b1;
        s_a_in    = 16'h1111;
        s_b_in    = 16'h2222;
        z_tot_in  = 8'h80;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        chk("b2b_in_ready", in_ready, 1'b1);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_out_valid", out_valid, 1'b0);
        chk("b2b_s_a", s_a, 16'h1111);
        stream(0, 2*BEATS, edges);
        chk("b2b_beats_to_valid", edges, 2*BEATS);
        verify_out(16'h1111, 16'h2222, 8'h80);
        prev_a = model_vec(0);
        prev_b = model_vec(BEATS);
        handshake();

        // Flush after five beats of a, with a beat offered in the flush cycle.
        fill_beats(1);
        do_start(16'h0101, 16'h0202, 8'h03);
        stream(0, 5, edges);
        new_a    = model_vec(0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = beats[5];
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", busy, 1'b0);
        exp_a = prev_a;
        exp_a[5*W-1:0] = new_a[5*W-1:0];
        chk_vec("flush_a_kept", a, exp_a);
        chk_vec("flush_b_kept", b, prev_b);
        chk("flush_s_a_kept", s_a, 16'h0101);
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("flush_out_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        fill_beats(1);
        do_start(16'h7777, 16'h8888, 8'hC0);
        stream(2, 2*BEATS, edges);
        verify_out(16'h7777, 16'h8888, 8'hC0);
        handshake();

        // Asynchronous reset part-way through operand b.
        fill_beats(1);
        sa = 16'($urandom) | 16'h1;
        do_start(sa, 16'h9999, 8'h11);
        stream(0, BEATS + 4, edges);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk_vec("arst_a", a, '0);
        chk_vec("arst_b", b, '0);
        chk("arst_s_a", s_a, 16'h0);
        chk("arst_s_b", s_b, 16'h0);
        chk("arst_z_tot", z_tot, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_beats(0);
        do_start(16'h4000, 16'h2000, 8'hFD);
        stream(0, 2*BEATS, edges);
        chk("arst_reload_edges", edges + 1, 2*BEATS + 1);
        verify_out(16'h4000, 16'h2000, 8'hFD);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_operand_loader.md
Name: add_operand_loader

Overview:
- Upstream feeder for the element-wise add execution unit.
- Receives a narrow stream of W-bit beats from the activation buffer and assembles two full N-lane int8 operand vectors, a and then b.
- Latches the per-operation scaling and zero-point values, then presents operands plus scaling to the add stage under a valid/ready handshake.
- Single operand buffer. No double buffering.

Parameters:
- N, 176, number of int8 lanes per operand vector (matches the add unit).
- W, 128, input beat width in bits. N*8 must be an integer multiple of W; elaboration-time assertion fails otherwise.
- BEATS, N*8/W (derived localparam, 11 at defaults), beats per operand.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new operand load; sampled only in IDLE
- flush  in  1  synchronous abort to IDLE
- s_a_in  in  16  scale for operand a, latched on accepted start
- s_b_in  in  16  scale for operand b, latched on accepted start
- z_tot_in  in  8  signed combined zero point, latched on accepted start
- in_valid  in  1  input beat valid
- in_ready  out  1  loader accepts a beat
- in_data  in  W  input beat; byte j is lane (beat_idx*W/8 + j)
- out_valid  out  1  a, b and scaling outputs are valid
- out_ready  in  1  add stage consumes the operands
- a  out  N*8  assembled operand a, lane i at [i*8 +: 8]
- b  out  N*8  assembled operand b
- s_a  out  16  latched scale a
- s_b  out  16  latched scale b
- z_tot  out  8  signed latched zero point
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- On reset: state=IDLE, beat counter=0. a, b, s_a, s_b, z_tot = 0. out_valid=0, in_ready=0, busy=0.
- States are IDLE, LOAD_A, LOAD_B and OUT.
- IDLE: if start=1, latch s_a_in, s_b_in and z_tot_in into s_a, s_b and z_tot, clear the counter, and go to LOAD_A.
- LOAD_A:
  - in_ready=1.
  - Each beat (in_valid && in_ready) writes a[cnt*W +: W] = in_data and increments cnt.
  - On the beat with cnt==BEATS-1: clear cnt and go to LOAD_B in the next cycle.
  - No bubble between A and B: in_ready stays 1 across the transition.
- LOAD_B: same as LOAD_A, but writes into b. After the last beat, go to OUT.
- OUT:
  - out_valid=1, in_ready=0.
  - a, b, s_a, s_b and z_tot are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, leave OUT.
  - If start=1 in that same cycle: go straight to LOAD_A, latch the new scaling, and clear the counter. Zero bubble for back-to-back operations.
  - Otherwise go to IDLE.
- Latency: the first out_valid comes 1 cycle after the 2*BEATS-th accepted beat (registered state). Minimum start-to-out_valid is 2*BEATS+1 cycles (23 at defaults).
- start outside IDLE, and outside the OUT handshake cycle, is ignored.
- flush:
  - Has priority over all other events.
  - Next state is IDLE, cnt=0, out_valid=0.
  - a, b and the scaling registers keep their contents.
  - A beat presented in the flush cycle is not accepted: in_ready is forced to 0 combinationally while flush=1.
- Reset mid-load: the asynchronous clear returns every register to reset values immediately. Partial vectors are discarded.
- in_valid while in_ready=0 is a no-op. in_data is don't-care when in_valid=0.
- Counter width is $clog2(BEATS). The counter never exceeds BEATS-1.
- No arithmetic is performed. Bytes are copied bit-exact; the int8 sign interpretation is the consumer's responsibility.

Decomposition:
- Shared exec-unit package holds:
  - the lane count constant (176) and the beat width constant (128);
  - the scale type (16-bit unsigned) and the zero-point type (8-bit signed);
  - the loader state enum.
- One natural sub-module, vec_assembler: a counter plus W-bit slice write-enable into an N*8 register with a done pulse.
  - Instantiated twice, once for a and once for b, with start/enable from the top-level FSM.

Test Plan:
- Basic load:
  - Stimulus: start with s_a=0x4000, s_b=0x2000, z_tot=-3. Stream 22 beats, beat k filled with byte value k (beats 0-10 to a, 11-21 to b), in_valid always 1.
  - Required: in_ready high for exactly 22 consecutive cycles. out_valid rises 1 cycle after beat 21. a lanes 0-15=0x00 and lanes 160-175=0x0A. b lanes 0-15=0x0B. s_a=0x4000, z_tot=0xFD.
- Input gaps:
  - Stimulus: same data with in_valid toggling 1/0.
  - Required: identical a/b contents; out_valid after 22 accepted beats (about 44 cycles).
- Output backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in OUT while driving in_valid=1 with junk.
  - Required: in_ready=0 and a/b/scaling unchanged throughout. Handshake on cycle 11, then IDLE with busy=0.
- Back-to-back:
  - Stimulus: assert start with s_a=0x1111 in the out_valid&&out_ready cycle.
  - Required: next cycle state is LOAD_A with in_ready=1 and s_a=0x1111. No IDLE cycle.
- Flush mid-load:
  - Stimulus: assert flush after 5 beats of a, with in_valid=1 in the flush cycle.
  - Required: that beat is not accepted, busy=0 the next cycle, out_valid never asserts. A later full load produces a correct vector starting from beat 0.
- Async reset:
  - Stimulus: drive rst_n low mid-LOAD_B, between clock edges.
  - Required: out_valid, in_ready, busy, a, b and scaling all 0 immediately. After release, start loads normally.
